// File: rtl/usr_pkg.sv
// Shared definitions for the 16-bit universal shift register and its serializer sequencer.
package usr_pkg;

    localparam int unsigned USR_WIDTH = 16;

    localparam logic [1:0] NO_OPERATIONS      = 2'h0;
    localparam logic [1:0] SHIFT_DATA_LEFT    = 2'h1;
    localparam logic [1:0] SHIFT_DATA_RIGHT   = 2'h2;
    localparam logic [1:0] LOAD_PARALLEL_DATA = 2'h3;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } seq_state_e;

endpackage

// File: rtl/usr_serializer_sequencer.sv
// Loads parallel words into the USR and shifts them out as a framed serial stream.
// All outputs except Serial_Data_Out are registered copies of the next-state decode.
module usr_serializer_sequencer
    import usr_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned COUNT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Tx_Data_In,
    input  logic                  Tx_Valid_In,
    output logic                  Tx_Ready_Out,
    input  logic                  Shift_Direction_In,
    input  logic                  Fill_Bit_In,
    output logic                  USR_Enable_Out,
    output logic [1:0]            USR_Operation_Select_Out,
    output logic                  USR_Serial_Left_Side_Data_Out,
    output logic                  USR_Serial_Right_Side_Data_Out,
    output logic [DATA_WIDTH-1:0] USR_Parallel_Data_Out,
    input  logic                  USR_Serial_Left_Side_Data_In,
    input  logic                  USR_Serial_Right_Side_Data_In,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Frame_Start_Out,
    output logic                  Frame_Done_Out,
    output logic                  Busy_Out
);

    localparam logic [COUNT_WIDTH-1:0] LAST_CNT = COUNT_WIDTH'(DATA_WIDTH - 1);

    seq_state_e             state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  word_q, word_d;
    logic                   dir_q, dir_d;
    logic                   fill_q, fill_d;

    logic                   ready_d, busy_d, valid_d, start_d, done_d;
    logic [1:0]             op_d;
    logic                   left_fill_d, right_fill_d;

    // State, holding registers and registered outputs
    always_ff @(posedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q                        <= IDLE;
            cnt_q                          <= '0;
            word_q                         <= '0;
            dir_q                          <= 1'b0;
            fill_q                         <= 1'b0;
            Tx_Ready_Out                   <= 1'b0;
            Busy_Out                       <= 1'b0;
            Serial_Valid_Out               <= 1'b0;
            Frame_Start_Out                <= 1'b0;
            Frame_Done_Out                 <= 1'b0;
            USR_Enable_Out                 <= 1'b0;
            USR_Operation_Select_Out       <= NO_OPERATIONS;
            USR_Serial_Left_Side_Data_Out  <= 1'b0;
            USR_Serial_Right_Side_Data_Out <= 1'b0;
        end else begin
            state_q                        <= state_d;
            cnt_q                          <= cnt_d;
            word_q                         <= word_d;
            dir_q                          <= dir_d;
            fill_q                         <= fill_d;
            Tx_Ready_Out                   <= ready_d;
            Busy_Out                       <= busy_d;
            Serial_Valid_Out               <= valid_d;
            Frame_Start_Out                <= start_d;
            Frame_Done_Out                 <= done_d;
            USR_Enable_Out                 <= 1'b1;
            USR_Operation_Select_Out       <= op_d;
            USR_Serial_Left_Side_Data_Out  <= left_fill_d;
            USR_Serial_Right_Side_Data_Out <= right_fill_d;
        end
    end

    // Next state plus output decode of that next state
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        dir_d        = dir_q;
        fill_d       = fill_q;
        ready_d      = 1'b0;
        busy_d       = 1'b0;
        valid_d      = 1'b0;
        start_d      = 1'b0;
        done_d       = 1'b0;
        op_d         = NO_OPERATIONS;
        left_fill_d  = 1'b0;
        right_fill_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (Tx_Valid_In && Tx_Ready_Out) begin
                    word_d  = Tx_Data_In;
                    dir_d   = Shift_Direction_In;
                    fill_d  = Fill_Bit_In;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + COUNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        case (state_d)
            IDLE: ready_d = 1'b1;
            LOAD: begin
                busy_d = 1'b1;
                op_d   = LOAD_PARALLEL_DATA;
            end
            SHIFT: begin
                busy_d  = 1'b1;
                valid_d = 1'b1;
                start_d = (cnt_d == '0);
                done_d  = (cnt_d == LAST_CNT);
                if (cnt_d != LAST_CNT) begin
                    op_d = (dir_d == LSB_FIRST) ? SHIFT_DATA_RIGHT : SHIFT_DATA_LEFT;
                end
                // Fill enters at the end the register is shifting away from
                left_fill_d  = (dir_d == LSB_FIRST) ? fill_d : 1'b0;
                right_fill_d = (dir_d == MSB_FIRST) ? fill_d : 1'b0;
            end
            default: ready_d = 1'b0;
        endcase
    end

    assign USR_Parallel_Data_Out = word_q;

    // Serial bit comes straight from whichever USR end is being shifted out
    assign Serial_Data_Out = Serial_Valid_Out &
        ((dir_q == LSB_FIRST) ? USR_Serial_Right_Side_Data_In : USR_Serial_Left_Side_Data_In);

endmodule

// File: tb/tb_usr_serializer_sequencer.sv
// Directed bench for usr_serializer_sequencer driving a behavioural 16-bit USR.
module tb_usr_serializer_sequencer;
    import usr_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic        dir_in = 1'b0;
    logic        fill_in = 1'b0;
    logic        usr_en;
    logic [1:0]  usr_op;
    logic        usr_left_in, usr_right_in;
    logic [15:0] usr_par;
    logic        ser_data, ser_valid, f_start, f_done, busy;
    logic [15:0] usr_q;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usr_serializer_sequencer dut (
        .Clk_In                         (clk),
        .Reset_In                       (rst),
        .Tx_Data_In                     (tx_data),
        .Tx_Valid_In                    (tx_valid),
        .Tx_Ready_Out                   (tx_ready),
        .Shift_Direction_In             (dir_in),
        .Fill_Bit_In                    (fill_in),
        .USR_Enable_Out                 (usr_en),
        .USR_Operation_Select_Out       (usr_op),
        .USR_Serial_Left_Side_Data_Out  (usr_left_in),
        .USR_Serial_Right_Side_Data_Out (usr_right_in),
        .USR_Parallel_Data_Out          (usr_par),
        .USR_Serial_Left_Side_Data_In   (usr_q[15]),
        .USR_Serial_Right_Side_Data_In  (usr_q[0]),
        .Serial_Data_Out                (ser_data),
        .Serial_Valid_Out               (ser_valid),
        .Frame_Start_Out                (f_start),
        .Frame_Done_Out                 (f_done),
        .Busy_Out                       (busy)
    );

    // Behavioural universal shift register
    always @(posedge clk or posedge rst) begin
        if (rst) usr_q <= '0;
        else if (usr_en) begin
            case (usr_op)
                SHIFT_DATA_LEFT:    usr_q <= {usr_q[14:0], usr_right_in};
                SHIFT_DATA_RIGHT:   usr_q <= {usr_left_in, usr_q[15:1]};
                LOAD_PARALLEL_DATA: usr_q <= usr_par;
                default:            usr_q <= usr_q;
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word once ready is seen, then clock the accept edge
    task automatic start_word(input logic [15:0] w, input logic d, input logic f, input bit hold);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_timeout: got %b want 1", tx_ready);
        end
        tx_data  = w;
        dir_in   = d;
        fill_in  = f;
        tx_valid = 1'b1;
        tick();
        if (!hold) tx_valid = 1'b0;
    endtask

    // Called just after the accept edge; follows LOAD, 16 bits and the return to IDLE
    task automatic collect(input logic [15:0] w, input logic d, input logic f,
                           input logic [0:15] stream, input logic [15:0] final_usr,
                           input bit toggle);
        logic [1:0] sop;
        sop = (d == LSB_FIRST) ? SHIFT_DATA_RIGHT : SHIFT_DATA_LEFT;
        checks++;
        if (usr_op !== LOAD_PARALLEL_DATA || usr_par !== w || tx_ready !== 1'b0 || busy !== 1'b1 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_cycle: op=%h par=%h rdy=%b busy=%b vld=%b want op=3 par=%h rdy=0 busy=1 vld=0",
                     usr_op, usr_par, tx_ready, busy, ser_valid, w);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            if (toggle) begin
                dir_in  = ~dir_in;
                fill_in = ~fill_in;
                tx_data = ~tx_data;
            end
            checks++;
            if (ser_valid !== 1'b1 || ser_data !== stream[i] || f_start !== (i == 0) || f_done !== (i == 15)) begin
                errors++;
                $display("FAIL bit%0d: vld=%b data=%b start=%b done=%b want 1 %b %b %b",
                         i, ser_valid, ser_data, f_start, f_done, stream[i], (i == 0), (i == 15));
            end
            checks++;
            if (tx_ready !== 1'b0 || busy !== 1'b1 || usr_op !== ((i < 15) ? sop : NO_OPERATIONS)) begin
                errors++;
                $display("FAIL ctrl%0d: rdy=%b busy=%b op=%h want 0 1 %h",
                         i, tx_ready, busy, usr_op, ((i < 15) ? sop : NO_OPERATIONS));
            end
            checks++;
            if (usr_left_in !== ((d == LSB_FIRST) ? f : 1'b0) || usr_right_in !== ((d == MSB_FIRST) ? f : 1'b0)) begin
                errors++;
                $display("FAIL fill%0d: left=%b right=%b", i, usr_left_in, usr_right_in);
            end
        end
        tick();
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0 || ser_valid !== 1'b0 || f_done !== 1'b0 || usr_q !== final_usr) begin
            errors++;
            $display("FAIL frame_end: rdy=%b busy=%b vld=%b done=%b usr=%h want 1 0 0 0 %h",
                     tx_ready, busy, ser_valid, f_done, usr_q, final_usr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({tx_ready, ser_valid, f_start, f_done, busy, usr_en} !== 6'b0 || usr_op !== NO_OPERATIONS || usr_par !== 16'h0) begin
            errors++;
            $display("FAIL reset_values: rdy=%b vld=%b st=%b dn=%b busy=%b en=%b op=%h par=%h",
                     tx_ready, ser_valid, f_start, f_done, busy, usr_en, usr_op, usr_par);
        end
        #2 rst = 1'b0;
        tick();
        checks++;
        if (usr_en !== 1'b1 || tx_ready !== 1'b1 || usr_op !== NO_OPERATIONS) begin
            errors++;
            $display("FAIL post_reset: en=%b rdy=%b op=%h want 1 1 0", usr_en, tx_ready, usr_op);
        end
    endtask

    task automatic test_msb_first();
        start_word(16'hA5C3, MSB_FIRST, 1'b1, 1'b0);
        collect(16'hA5C3, MSB_FIRST, 1'b1, 16'b1010_0101_1100_0011, 16'hFFFF, 1'b0);
    endtask

    task automatic test_lsb_first();
        start_word(16'h0001, LSB_FIRST, 1'b0, 1'b0);
        collect(16'h0001, LSB_FIRST, 1'b0, 16'b1000_0000_0000_0000, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        start_word(16'h1234, MSB_FIRST, 1'b0, 1'b1);
        tx_data = 16'hBEEF;
        collect(16'h1234, MSB_FIRST, 1'b0, 16'b0001_0010_0011_0100, 16'h0000, 1'b0);
        tick();
        collect(16'hBEEF, MSB_FIRST, 1'b0, 16'b1011_1110_1110_1111, 16'h8000, 1'b0);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        start_word(16'hFFFF, MSB_FIRST, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (ser_valid !== 1'b1 || ser_data !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_bit7: vld=%b data=%b want 1 1", ser_valid, ser_data);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({tx_ready, ser_valid, ser_data, f_start, f_done, busy, usr_en, usr_left_in, usr_right_in} !== 9'b0 ||
            usr_op !== NO_OPERATIONS || usr_par !== 16'h0 || usr_q !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: rdy=%b vld=%b d=%b st=%b dn=%b busy=%b en=%b op=%h par=%h usr=%h",
                     tx_ready, ser_valid, ser_data, f_start, f_done, busy, usr_en, usr_op, usr_par, usr_q);
        end
        tick();
        checks++;
        if (f_done !== 1'b0 || ser_valid !== 1'b0) begin
            errors++;
            $display("FAIL no_done_in_reset: done=%b vld=%b want 0 0", f_done, ser_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (tx_ready !== 1'b0 || usr_en !== 1'b0) begin
            errors++;
            $display("FAIL before_first_edge: rdy=%b en=%b want 0 0", tx_ready, usr_en);
        end
        tick();
        checks++;
        if (tx_ready !== 1'b1 || usr_en !== 1'b1 || f_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_release: rdy=%b en=%b done=%b busy=%b want 1 1 0 0",
                     tx_ready, usr_en, f_done, busy);
        end
    endtask

    task automatic test_input_toggle();
        start_word(16'h8001, MSB_FIRST, 1'b0, 1'b0);
        collect(16'h8001, MSB_FIRST, 1'b0, 16'b1000_0000_0000_0001, 16'h8000, 1'b1);
        dir_in  = 1'b0;
        fill_in = 1'b0;
    endtask

    task automatic test_idle();
        tx_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (usr_op !== NO_OPERATIONS || ser_valid !== 1'b0 || usr_q !== 16'h8000 || tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle%0d: op=%h vld=%b usr=%h rdy=%b want 0 0 8000 1", i, usr_op, ser_valid, usr_q, tx_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_reset_mid_frame();
        test_input_toggle();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
